// File: rtl/pc_sequencer.sv
// pc_sequencer: holds the architectural PC and selects the next PC from
// sequential, branch, jump and jump-register sources, with a reset-hold cycle and sticky misalignment fault.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [3:0]  jump_region,
    output logic [27:0] jump_addr,
    output logic        fetch_valid,
    output logic        misalign_fault
);
    typedef enum logic [1:0] {HOLD, RUN, FAULT} state_t;
    state_t state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] branch_off;
    logic        jr_bad;
    assign pc_plus4       = pc + 32'd4;
    assign jump_region    = pc_plus4[31:28];
    assign jump_addr      = {jump_index, 2'b00};
    assign branch_off     = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign jr_bad         = |jr_target[1:0];
    assign fetch_valid    = state == RUN;
    assign misalign_fault = state == FAULT;
    // A misaligned jr freezes pc and parks the sequencer in FAULT until reset.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (state == HOLD) begin
            state_nxt = RUN;
        end else if (state == RUN && !stall) begin
            state_nxt = (jr && jr_bad) ? FAULT : RUN;
            pc_nxt    = jr           ? (jr_bad ? pc : jr_target) :
                        jump         ? {jump_region, jump_addr} :
                        branch_taken ? pc_plus4 + branch_off :
                                       pc_plus4;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HOLD;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed tests of reset-hold, redirect priority, stall,
// misalignment fault and PC/region wrap behaviour.
module tb_pc_sequencer;
    logic        clk = 0;
    logic        rst_n, stall, jump, branch_taken, jr;
    logic [25:0] jump_index;
    logic [15:0] branch_imm;
    logic [31:0] jr_target;
    logic [31:0] pc, pc_plus4;
    logic [3:0]  jump_region;
    logic [27:0] jump_addr;
    logic        fetch_valid, misalign_fault;
    int checks = 0;
    int failures = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump), .jump_index(jump_index),
        .branch_taken(branch_taken), .branch_imm(branch_imm), .jr(jr), .jr_target(jr_target),
        .pc(pc), .pc_plus4(pc_plus4), .jump_region(jump_region), .jump_addr(jump_addr),
        .fetch_valid(fetch_valid), .misalign_fault(misalign_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; jump = 0; branch_taken = 0; jr = 0;
        jump_index = '0; branch_imm = '0; jr_target = '0;
    endtask

    task automatic set_pc(input logic [31:0] v);
        jr = 1; jr_target = v;
        step();
        jr = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        step(); step();
        checks++;
        if (pc !== 32'h100 || fetch_valid !== 1'b0 || misalign_fault !== 1'b0) begin
            failures++; $display("FAIL reset pc=%h fv=%b mf=%b exp pc=00000100 fv=0 mf=0", pc, fetch_valid, misalign_fault);
        end
        rst_n = 1;
        jump = 1; jump_index = 26'h3;
        checks++;
        if (pc !== 32'h100 || fetch_valid !== 1'b0) begin
            failures++; $display("FAIL hold_cycle pc=%h fv=%b exp pc=00000100 fv=0", pc, fetch_valid);
        end
        step();
        jump = 0;
        checks++;
        if (pc !== 32'h100 || fetch_valid !== 1'b1) begin
            failures++; $display("FAIL run_entry pc=%h fv=%b exp pc=00000100 fv=1", pc, fetch_valid);
        end
        step();
        checks++;
        if (pc !== 32'h104) begin failures++; $display("FAIL seq1 pc=%h exp=00000104", pc); end
        step();
        checks++;
        if (pc !== 32'h108) begin failures++; $display("FAIL seq2 pc=%h exp=00000108", pc); end
    endtask

    task automatic test_jump();
        set_pc(32'h1000_0010);
        checks++;
        if (pc !== 32'h1000_0010) begin failures++; $display("FAIL jr_load pc=%h exp=10000010", pc); end
        jump = 1; jump_index = 26'h0000040; stall = 1;
        #1;
        checks++;
        if (jump_region !== 4'h1 || jump_addr !== 28'h0000100) begin
            failures++; $display("FAIL jump_fields region=%h addr=%h exp region=1 addr=0000100", jump_region, jump_addr);
        end
        step();
        checks++;
        if (pc !== 32'h1000_0010) begin failures++; $display("FAIL jump_stall pc=%h exp=10000010", pc); end
        stall = 0;
        step();
        jump = 0;
        checks++;
        if (pc !== 32'h1000_0100) begin failures++; $display("FAIL jump pc=%h exp=10000100", pc); end
    endtask

    task automatic test_branch();
        set_pc(32'h0000_0020);
        branch_taken = 1; branch_imm = 16'hFFFC;
        step();
        checks++;
        if (pc !== 32'h0000_0014) begin failures++; $display("FAIL branch_back pc=%h exp=00000014", pc); end
        branch_taken = 0;
        set_pc(32'h0000_0020);
        branch_taken = 1; branch_imm = 16'h0004;
        step();
        checks++;
        if (pc !== 32'h0000_0034) begin failures++; $display("FAIL branch_fwd pc=%h exp=00000034", pc); end
        branch_taken = 0;
        set_pc(32'h0000_0004);
        branch_taken = 1; branch_imm = 16'hFFF0;
        step();
        branch_taken = 0;
        checks++;
        if (pc !== 32'hFFFF_FFC8 || misalign_fault !== 1'b0) begin
            failures++; $display("FAIL branch_wrap pc=%h mf=%b exp pc=ffffffc8 mf=0", pc, misalign_fault);
        end
    endtask

    task automatic test_stall();
        set_pc(32'h0000_0200);
        stall = 1; jr = 1; jr_target = 32'h0000_0003; branch_taken = 1; branch_imm = 16'h0010;
        step(); step();
        checks++;
        if (pc !== 32'h0000_0200 || misalign_fault !== 1'b0 || fetch_valid !== 1'b1) begin
            failures++; $display("FAIL stall_hold pc=%h mf=%b fv=%b exp pc=00000200 mf=0 fv=1", pc, misalign_fault, fetch_valid);
        end
        idle();
        step();
        checks++;
        if (pc !== 32'h0000_0204) begin failures++; $display("FAIL stall_no_memory pc=%h exp=00000204", pc); end
    endtask

    task automatic test_priority_fault();
        jr = 1; jump = 1; branch_taken = 1; jump_index = 26'h10; branch_imm = 16'h0040;
        jr_target = 32'h0000_0800;
        step();
        checks++;
        if (pc !== 32'h0000_0800 || misalign_fault !== 1'b0) begin
            failures++; $display("FAIL priority_jr pc=%h mf=%b exp pc=00000800 mf=0", pc, misalign_fault);
        end
        jr_target = 32'h0000_0802;
        step();
        checks++;
        if (pc !== 32'h0000_0800 || misalign_fault !== 1'b1 || fetch_valid !== 1'b0) begin
            failures++; $display("FAIL fault_entry pc=%h mf=%b fv=%b exp pc=00000800 mf=1 fv=0", pc, misalign_fault, fetch_valid);
        end
        jr = 0; branch_taken = 0; jump = 1; jump_index = 26'h5;
        step(); step();
        checks++;
        if (pc !== 32'h0000_0800 || misalign_fault !== 1'b1 || fetch_valid !== 1'b0) begin
            failures++; $display("FAIL fault_sticky pc=%h mf=%b fv=%b exp pc=00000800 mf=1 fv=0", pc, misalign_fault, fetch_valid);
        end
        rst_n = 0;
        step();
        checks++;
        if (pc !== 32'h0000_0100 || misalign_fault !== 1'b0 || fetch_valid !== 1'b0) begin
            failures++; $display("FAIL fault_reset pc=%h mf=%b fv=%b exp pc=00000100 mf=0 fv=0", pc, misalign_fault, fetch_valid);
        end
        idle();
        rst_n = 1;
        step();
        checks++;
        if (pc !== 32'h0000_0100 || fetch_valid !== 1'b1) begin
            failures++; $display("FAIL rerun pc=%h fv=%b exp pc=00000100 fv=1", pc, fetch_valid);
        end
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        checks++;
        if (pc_plus4 !== 32'h0 || jump_region !== 4'h0) begin
            failures++; $display("FAIL wrap_plus4 pc_plus4=%h region=%h exp pc_plus4=00000000 region=0", pc_plus4, jump_region);
        end
        step();
        checks++;
        if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc pc=%h exp=00000000", pc); end
    endtask

    task automatic test_region();
        set_pc(32'h0FFF_FFFC);
        jump = 1; jump_index = 26'h0;
        #1;
        checks++;
        if (jump_region !== 4'h1 || jump_addr !== 28'h0) begin
            failures++; $display("FAIL region_fields region=%h addr=%h exp region=1 addr=0000000", jump_region, jump_addr);
        end
        step();
        jump = 0;
        checks++;
        if (pc !== 32'h1000_0000) begin failures++; $display("FAIL region_jump pc=%h exp=10000000", pc); end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_branch();
        test_stall();
        test_priority_fault();
        test_wrap();
        test_region();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
